input_debouncer: RTL

Conditions the raw front-panel switch/button inputs before they reach the `simple_fpga_cvs` logic inputs (in0, in1, in2, …). Each channel is double-flop synchronised to the system clock, filtered so that only levels held stable for `STABLE_CYCLES` consecutive clocks propagate, and decorated with single-cycle edge pulses and a per-channel toggle latch for push-button use. All channels share one counter design instantiated per channel. Channels are otherwise independent.

---
 rtl/input_debouncer.sv | 78 +++++++
 1 files changed

// File: rtl/input_debouncer.sv
// Multi-channel switch conditioner: two-flop synchroniser, stability filter,
// registered edge pulses and a push-button toggle latch per channel.
module input_debouncer #(
   parameter int CHANNELS      = 5,
   parameter int STABLE_CYCLES = 300000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] raw,
   output logic [CHANNELS-1:0] clean,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] toggle,
   output logic                any_change
);

   localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(STABLE_CYCLES - 1);

   logic [CHANNELS-1:0] sync_p0;
   logic [CHANNELS-1:0] sync_p1;
   logic [CHANNELS-1:0] qualify_rise;
   logic [CHANNELS-1:0] qualify_fall;

   // Counter never passes TERMINAL: reaching it either commits the level or a
   // match clears it, so the register cannot wrap.
   function automatic logic [CNT_W-1:0] advance(input logic [CNT_W-1:0] count,
                                                input logic              differs);
      if (!differs || count == TERMINAL) advance = '0;
      else                                advance = count + CNT_W'(1);
   endfunction

   // Stage p0/p1: metastability hardening of the asynchronous switch levels
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      logic [CNT_W-1:0] count;
      logic             differs;
      logic             at_terminal;

      assign differs     = sync_p1[i] ^ clean[i];
      assign at_terminal = differs && (count == TERMINAL);

      always_ff @(posedge clock or posedge reset) begin
         if (reset) count <= '0;
         else       count <= advance(count, differs);
      end

      assign qualify_rise[i] = at_terminal &  sync_p1[i];
      assign qualify_fall[i] = at_terminal & ~sync_p1[i];
   end

   // Stage p2: accepted level plus its pulses, all registered together
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clean      <= '0;
         rise       <= '0;
         fall       <= '0;
         toggle     <= '0;
         any_change <= 1'b0;
      end else begin
         clean      <= clean ^ (qualify_rise | qualify_fall);
         rise       <= qualify_rise;
         fall       <= qualify_fall;
         toggle     <= toggle ^ qualify_rise;
         any_change <= |(qualify_rise | qualify_fall);
      end
   end

endmodule
